sram_dp_be: RTL and testbench
=============================

# sram_dp_be

Parametrised simple-dual-port scratch SRAM for the CNN datapath. It replaces the single-port byte-wide buffer with these features:

- independent read and write ports usable in the same cycle;
- per-byte write enables;
- write-first forwarding on address collision;
- selectable read latency;
- a sequenced clear engine, so the array is never zeroed combinationally on reset.

It sits between the layer controller and the PE array as weight/activation storage.

## Interface
- ADDR_WIDTH, 8, address bits; DEPTH = 1<<ADDR_WIDTH words
- DATA_WIDTH, 32, word width; must be a multiple of 8; NB = DATA_WIDTH/8 byte lanes
- RD_LATENCY, 1, read latency in cycles; legal values 1 or 2 (elaboration error otherwise)

Ports:
- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- clear_req  in  1  pulse: re-zero whole array
- ready  out  1  block accepts read/write requests
- wr_valid  in  1  write request
- wr_addr  in  ADDR_WIDTH  write address
- wr_data  in  DATA_WIDTH  write data
- wr_be  in  NB  byte enables; bit i covers data[8i+7:8i]
- rd_valid  in  1  read request
- rd_addr  in  ADDR_WIDTH  read address
- rd_data  out  DATA_WIDTH  read data
- rd_data_valid  out  1  rd_data valid this cycle

## Operation
- FSM states: S_CLEAR, S_READY. Reset enters S_CLEAR with clr_cnt=0.
- **S_CLEAR**
  - Each cycle writes mem[clr_cnt]=0 and increments clr_cnt.
  - On the edge that writes DEPTH-1, go to S_READY and set ready=1.
  - wr_valid/rd_valid are ignored; no handshake, requests are dropped.
- **S_READY**
  - A write is accepted when wr_valid && ready: for each i with wr_be[i]=1, byte i of mem[wr_addr] <= wr_data byte i. Bytes with wr_be[i]=0 are unchanged. wr_be=0 is a legal no-op.
  - A read is accepted when rd_valid && ready.
  - A read and a write may be accepted in the same cycle to any addresses.
- **Collision (write-first).** Same-cycle read and write with rd_addr==wr_addr: the read returns the merged word, i.e. wr_data bytes where wr_be=1 and old mem bytes elsewhere.
- **clear_req.**
  - Sampled only in S_READY. Requests accepted in the same cycle still execute.
  - Next cycle: ready=0, state S_CLEAR, clr_cnt=0.
  - clear_req in S_CLEAR is ignored; the clear is not restarted.
- **Reads in flight.** Reads accepted before a clear still return their captured data, unaffected by the clear.
- **Reset mid-operation.** Async reset flushes the read pipeline (rd_data_valid=0, rd_data=0) and restarts the clear from address 0.

## Timing
- Reset values: ready=0, rd_data='0, rd_data_valid=0, state S_CLEAR, clr_cnt=0.
- Clear duration: ready rises exactly DEPTH rising edges after rst_n deasserts, or DEPTH+1 edges after the clear_req cycle.
- Read latency:
  - RD_LATENCY=1: rd_data/rd_data_valid are registered and valid the cycle after acceptance.
  - RD_LATENCY=2: one extra output stage.
  - Full throughput of one read per cycle at either latency.
- rd_data holds its last value when rd_data_valid=0.
- A write is visible to a non-colliding read accepted on the following cycle.
- ready is registered; it never depends combinationally on inputs.

## Structure
- Package sram_pkg holds:
  - typedef enum logic {S_CLEAR, S_READY} sram_state_t;
  - function nbytes(DATA_WIDTH).
- Sub-module sram_clear_seq holds the FSM, the ADDR_WIDTH-bit clr_cnt and ready. It outputs clr_we and clr_addr.
- Top-level content:
  - Array write mux: clear has priority; it is exclusive with user writes by construction.
  - Byte-enable write loop.
  - Collision merge.
  - Parameter-selected read pipeline.

## Test plan
- **Reset/clear.** Release rst_n with ADDR_WIDTH=4 -> ready=0 for 16 cycles, then 1. A read of every address returns 0, and rd_data_valid is 0 throughout reset.
- **Byte enables.**
  - Write 0xDEADBEEF to addr 5 with be=1111, then 0x11223344 with be=0101.
  - Read addr 5 -> 0xDE22BE44, one cycle after acceptance (RD_LATENCY=1).
- **Collision.**
  - mem[7]=0xAABBCCDD; same cycle write 0x00000011 be=0001 and read addr 7 -> 0xAABBCC11.
  - Non-colliding same-cycle read returns old data.
- **Latency/throughput.** RD_LATENCY=2, back-to-back reads of addr 0..3 -> rd_data_valid high 4 consecutive cycles starting 2 cycles after the first accept, with data in order.
- **clear_req mid-stream.**
  - Issue a read of addr 3 (0x1234) together with clear_req -> read returns 0x1234.
  - ready=0 for DEPTH cycles; writes during that window are dropped; addr 3 reads 0 afterwards.
- **Reset mid-clear.** Assert rst_n low at clr_cnt=9 -> outputs return to reset values, and the clear restarts from 0 with full DEPTH duration.

Source files
------------

// File: rtl/sram_pkg.sv
// Shared types and helpers for the dual-port byte-enable scratch SRAM.
package sram_pkg;

    // Clear engine / service state of the SRAM.
    typedef enum logic {
        S_CLEAR = 1'b0,
        S_READY = 1'b1
    } sram_state_t;

    // Number of byte lanes in a data word.
    function automatic int nbytes(input int data_width);
        return data_width / 8;
    endfunction

endpackage

// File: rtl/sram_clear_seq.sv
// Clear sequencer: walks every address writing zero after reset or clear_req,
// then raises ready. The state register is exposed for debug and checkers.
module sram_clear_seq
    import sram_pkg::*;
#(
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear_req,
    output logic                  ready,
    output logic                  clr_we,
    output logic [ADDR_WIDTH-1:0] clr_addr,
    output sram_state_t           state
);

    localparam logic [ADDR_WIDTH-1:0] CNT_MAX = '1;
    localparam logic [ADDR_WIDTH-1:0] CNT_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

    sram_state_t           state_nxt;
    logic [ADDR_WIDTH-1:0] clr_cnt;
    logic [ADDR_WIDTH-1:0] clr_cnt_nxt;
    logic                  ready_nxt;

    // State, clear counter and ready register; reset restarts the clear at 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_CLEAR;
            clr_cnt <= '0;
            ready   <= 1'b0;
        end else begin
            state   <= state_nxt;
            clr_cnt <= clr_cnt_nxt;
            ready   <= ready_nxt;
        end
    end

    // Next-state logic: sweep addresses in S_CLEAR, wait for clear_req in S_READY.
    always_comb begin
        state_nxt   = state;
        clr_cnt_nxt = clr_cnt;
        ready_nxt   = ready;
        clr_we      = 1'b0;
        case (state)
            S_CLEAR: begin
                clr_we      = 1'b1;
                clr_cnt_nxt = clr_cnt + CNT_ONE;
                if (clr_cnt == CNT_MAX) begin
                    state_nxt = S_READY;
                    ready_nxt = 1'b1;
                end
            end
            S_READY: begin
                if (clear_req) begin
                    state_nxt   = S_CLEAR;
                    clr_cnt_nxt = '0;
                    ready_nxt   = 1'b0;
                end
            end
            default: begin
                state_nxt   = S_CLEAR;
                clr_cnt_nxt = '0;
                ready_nxt   = 1'b0;
            end
        endcase
    end

    assign clr_addr = clr_cnt;

endmodule

// File: rtl/sram_dp_be.sv
// Simple-dual-port scratch SRAM with per-byte write enables, write-first
// forwarding on same-address collisions, 1- or 2-cycle read latency and a
// sequenced clear engine.
// Handshake: a request is accepted on a rising edge where its valid and
// ready are both high; there is no backpressure on the read return path.
module sram_dp_be
    import sram_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32,
    parameter int RD_LATENCY = 1,
    localparam int NB    = nbytes(DATA_WIDTH),
    localparam int DEPTH = 1 << ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear_req,
    output logic                  ready,
    input  logic                  wr_valid,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [NB-1:0]         wr_be,
    input  logic                  rd_valid,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_data_valid
);

    if ((DATA_WIDTH % 8) != 0) begin : g_bad_dw
        $error("sram_dp_be: DATA_WIDTH must be a multiple of 8");
    end

    logic                  clr_we;
    logic [ADDR_WIDTH-1:0] clr_addr;
    sram_state_t           seq_state;
    logic                  wr_accept;
    logic                  rd_accept;
    logic [DATA_WIDTH-1:0] rd_word;
    logic [DATA_WIDTH-1:0] s1_data;
    logic                  s1_valid;
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    sram_clear_seq #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_clr (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear_req (clear_req),
        .ready     (ready),
        .clr_we    (clr_we),
        .clr_addr  (clr_addr),
        .state     (seq_state)
    );

    // User requests are only taken once the sequencer reports service state.
    assign wr_accept = wr_valid && ready && (seq_state == S_READY);
    assign rd_accept = rd_valid && ready && (seq_state == S_READY);

    // Array write port: clear wins; user writes only touch enabled byte lanes.
    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem[clr_addr] <= '0;
        end else if (wr_accept) begin
            for (int i = 0; i < NB; i++) begin
                if (wr_be[i]) begin
                    mem[wr_addr][8*i +: 8] <= wr_data[8*i +: 8];
                end
            end
        end
    end

    // Read word with write-first merge when the write targets the same address.
    always_comb begin
        rd_word = mem[rd_addr];
        if (wr_accept && (wr_addr == rd_addr)) begin
            for (int i = 0; i < NB; i++) begin
                if (wr_be[i]) begin
                    rd_word[8*i +: 8] = wr_data[8*i +: 8];
                end
            end
        end
    end

    // First read stage: captures data only on accept so it holds otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
        end else begin
            s1_valid <= rd_accept;
            if (rd_accept) begin
                s1_data <= rd_word;
            end
        end
    end

    if (RD_LATENCY == 1) begin : g_lat1
        assign rd_data       = s1_data;
        assign rd_data_valid = s1_valid;
    end else if (RD_LATENCY == 2) begin : g_lat2
        logic [DATA_WIDTH-1:0] s2_data;
        logic                  s2_valid;

        // Extra output stage; also holds its data while idle.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                s2_valid <= 1'b0;
                s2_data  <= '0;
            end else begin
                s2_valid <= s1_valid;
                if (s1_valid) begin
                    s2_data <= s1_data;
                end
            end
        end

        assign rd_data       = s2_data;
        assign rd_data_valid = s2_valid;
    end else begin : g_bad_lat
        $error("sram_dp_be: RD_LATENCY must be 1 or 2");
    end

endmodule

// File: tb/tb_sram_dp_be.sv
// Directed bench for sram_dp_be: two instances (read latency 1 and 2) share
// the same stimulus; each step checks hand-computed expected values.
module tb_sram_dp_be;

    localparam int AW    = 4;
    localparam int DW    = 32;
    localparam int NBT   = DW / 8;
    localparam int DEPTH = 1 << AW;

    logic          clk       = 1'b0;
    logic          rst_n     = 1'b0;
    logic          clear_req = 1'b0;
    logic          wr_valid  = 1'b0;
    logic [AW-1:0] wr_addr   = '0;
    logic [DW-1:0] wr_data   = '0;
    logic [NBT-1:0] wr_be    = '0;
    logic          rd_valid  = 1'b0;
    logic [AW-1:0] rd_addr   = '0;

    logic          ready1, ready2;
    logic [DW-1:0] rd_data1, rd_data2;
    logic          rdv1, rdv2;

    int n_pass  = 0;
    int n_fail  = 0;
    int n_total = 0;

    // Clock block
    always #5 clk = ~clk;

    sram_dp_be #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_LATENCY(1)) dut1 (
        .clk           (clk),
        .rst_n         (rst_n),
        .clear_req     (clear_req),
        .ready         (ready1),
        .wr_valid      (wr_valid),
        .wr_addr       (wr_addr),
        .wr_data       (wr_data),
        .wr_be         (wr_be),
        .rd_valid      (rd_valid),
        .rd_addr       (rd_addr),
        .rd_data       (rd_data1),
        .rd_data_valid (rdv1)
    );

    sram_dp_be #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_LATENCY(2)) dut2 (
        .clk           (clk),
        .rst_n         (rst_n),
        .clear_req     (clear_req),
        .ready         (ready2),
        .wr_valid      (wr_valid),
        .wr_addr       (wr_addr),
        .wr_data       (wr_data),
        .wr_be         (wr_be),
        .rd_valid      (rd_valid),
        .rd_addr       (rd_addr),
        .rd_data       (rd_data2),
        .rd_data_valid (rdv2)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock, then sample 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [NBT-1:0] be);
        wr_valid = 1'b1;
        wr_addr  = a;
        wr_data  = d;
        wr_be    = be;
        step();
        wr_valid = 1'b0;
        wr_be    = '0;
    endtask

    task automatic read_check1(input string tag, input logic [AW-1:0] a, input logic [DW-1:0] exp);
        rd_valid = 1'b1;
        rd_addr  = a;
        step();
        rd_valid = 1'b0;
        check({tag, "_vld"}, rdv1, 1);
        check(tag, rd_data1, exp);
    endtask

    // Watchdog: the directed sequence is a few hundred cycles.
    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // ---------------- reset values, reads ignored during reset
        rd_valid = 1'b1;
        step();
        step();
        check("rst_ready1", ready1, 0);
        check("rst_ready2", ready2, 0);
        check("rst_vld1", rdv1, 0);
        check("rst_vld2", rdv2, 0);
        check("rst_data1", rd_data1, 32'h0);
        check("rst_data2", rd_data2, 32'h0);

        // ---------------- clear after reset: requests dropped for DEPTH edges
        rst_n    = 1'b1;
        wr_valid = 1'b1;
        wr_addr  = 4'd2;
        wr_data  = 32'hFFFF_FFFF;
        wr_be    = 4'hF;
        for (int i = 1; i <= DEPTH; i++) begin
            step();
            check("clr_ready1", ready1, (i == DEPTH));
            check("clr_ready2", ready2, (i == DEPTH));
            check("clr_vld1", rdv1, 0);
        end
        wr_valid = 1'b0;
        wr_be    = '0;
        rd_valid = 1'b0;

        // ---------------- every address reads zero, back to back
        for (int a = 0; a < DEPTH; a++) begin
            read_check1("zero_rd", a[AW-1:0], 32'h0);
        end
        step();
        check("idle_vld1", rdv1, 0);

        // ---------------- byte enables
        do_write(4'd5, 32'hDEAD_BEEF, 4'b1111);
        do_write(4'd5, 32'h1122_3344, 4'b0101);
        read_check1("be_merge", 4'd5, 32'hDE22_BE44);
        do_write(4'd5, 32'hFFFF_FFFF, 4'b0000);
        read_check1("be_zero_noop", 4'd5, 32'hDE22_BE44);

        // ---------------- collision: write-first merge
        do_write(4'd7, 32'hAABB_CCDD, 4'b1111);
        wr_valid = 1'b1;
        wr_addr  = 4'd7;
        wr_data  = 32'h0000_0011;
        wr_be    = 4'b0001;
        read_check1("collide", 4'd7, 32'hAABB_CCDD & 32'hFFFF_FF00 | 32'h0000_0011);
        wr_valid = 1'b0;
        wr_be    = '0;
        read_check1("collide_stored", 4'd7, 32'hAABB_CC11);
        // non-colliding same-cycle read sees old data, write visible next cycle
        wr_valid = 1'b1;
        wr_addr  = 4'd7;
        wr_data  = 32'h5555_5555;
        wr_be    = 4'b1111;
        read_check1("no_collide_old", 4'd5, 32'hDE22_BE44);
        wr_valid = 1'b0;
        wr_be    = '0;
        read_check1("write_visible", 4'd7, 32'h5555_5555);

        // ---------------- latency 2 throughput on addr 0..3
        for (int a = 0; a < 4; a++) begin
            do_write(a[AW-1:0], 32'h1000_0000 | a, 4'hF);
        end
        rd_valid = 1'b1;
        rd_addr  = 4'd0;
        step();
        check("lat2_e0_vld", rdv2, 0);
        check("lat1_e0", rd_data1, 32'h1000_0000);
        rd_addr = 4'd1;
        step();
        check("lat2_e1_vld", rdv2, 1);
        check("lat2_e1", rd_data2, 32'h1000_0000);
        rd_addr = 4'd2;
        step();
        check("lat2_e2_vld", rdv2, 1);
        check("lat2_e2", rd_data2, 32'h1000_0001);
        rd_addr = 4'd3;
        step();
        check("lat2_e3_vld", rdv2, 1);
        check("lat2_e3", rd_data2, 32'h1000_0002);
        rd_valid = 1'b0;
        step();
        check("lat2_e4_vld", rdv2, 1);
        check("lat2_e4", rd_data2, 32'h1000_0003);
        check("lat1_e4_vld", rdv1, 0);
        step();
        check("lat2_e5_vld", rdv2, 0);
        check("lat2_hold", rd_data2, 32'h1000_0003);
        check("lat1_hold", rd_data1, 32'h1000_0003);

        // ---------------- clear_req mid-stream
        do_write(4'd3, 32'h0000_1234, 4'hF);
        clear_req = 1'b1;
        rd_valid  = 1'b1;
        rd_addr   = 4'd3;
        step();
        rd_valid = 1'b0;
        check("clrq_rd1_vld", rdv1, 1);
        check("clrq_rd1", rd_data1, 32'h0000_1234);
        check("clrq_ready_low", ready1, 0);
        // keep clear_req high and writes pending: both must be ignored
        wr_valid = 1'b1;
        wr_addr  = 4'd3;
        wr_data  = 32'hFFFF_FFFF;
        wr_be    = 4'hF;
        for (int i = 1; i <= DEPTH; i++) begin
            step();
            if (i == 1) begin
                check("clrq_rd2_vld", rdv2, 1);
                check("clrq_rd2", rd_data2, 32'h0000_1234);
            end
            check("clrq_ready1", ready1, (i == DEPTH));
        end
        wr_valid  = 1'b0;
        wr_be     = '0;
        clear_req = 1'b0;
        read_check1("clrq_addr3", 4'd3, 32'h0);
        read_check1("clrq_addr7", 4'd7, 32'h0);

        // ---------------- reset mid-clear
        do_write(4'd6, 32'hCAFE_F00D, 4'hF);
        clear_req = 1'b1;
        rd_valid  = 1'b1;
        rd_addr   = 4'd6;
        step();
        clear_req = 1'b0;
        rd_valid  = 1'b0;
        check("rmc_rd1", rd_data1, 32'hCAFE_F00D);
        for (int i = 1; i <= 9; i++) begin
            step();
        end
        check("rmc_clr_cnt", dut1.u_clr.clr_cnt, 9);
        check("rmc_hold1", rd_data1, 32'hCAFE_F00D);
        check("rmc_hold2", rd_data2, 32'hCAFE_F00D);
        rst_n = 1'b0;
        #1;
        check("rmc_data1", rd_data1, 32'h0);
        check("rmc_data2", rd_data2, 32'h0);
        check("rmc_vld1", rdv1, 0);
        check("rmc_ready1", ready1, 0);
        step();
        rst_n = 1'b1;
        for (int i = 1; i <= DEPTH; i++) begin
            step();
            check("rmc_ready", ready1, (i == DEPTH));
        end
        read_check1("rmc_addr6", 4'd6, 32'h0);

        // ---------------- report
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
